// File: rtl/step_driver.sv
// Turns the pulse generator's step-rate square wave into fixed-width STEP pulses
// with DIR setup time, a bounded move length and signed position tracking.
module step_driver #(
  parameter int unsigned PULSE_W   = 13,
  parameter int unsigned DIR_SETUP = 7
) (
  input  logic        sysclk,
  input  logic        reset_n,
  input  logic        pulse_in,
  input  logic        dir_in,
  input  logic        start,
  input  logic [31:0] target_steps,
  input  logic        enable,
  input  logic        clr_pos,
  output logic        step_out,
  output logic        dir_out,
  output logic [31:0] position,
  output logic [31:0] steps_done,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_RUN,
    S_HIGH,
    S_DONE
  } state_t;

  localparam logic [7:0] PW_LAST    = 8'(PULSE_W - 1);
  localparam logic [7:0] SETUP_LAST = 8'(DIR_SETUP - 1);

  state_t      state_q, state_d;
  logic [2:0]  sync_q, sync_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        step_out_q, step_out_d;
  logic        dir_out_q, dir_out_d;
  logic [31:0] position_q, position_d;
  logic [31:0] steps_done_q, steps_done_d;
  logic [31:0] target_q, target_d;
  logic        done_q, done_d;
  logic        overrun_q, overrun_d;
  logic        abort_q, abort_d;
  logic        step_inc;
  logic        pulse_rise;

  // sync_q[1:0] is the two-stage synchronizer, sync_q[2] the edge-detect delay
  assign pulse_rise = sync_q[1] & ~sync_q[2];

  always_comb begin
    state_d      = state_q;
    sync_d       = {sync_q[1:0], pulse_in};
    cnt_d        = cnt_q;
    step_out_d   = step_out_q;
    dir_out_d    = dir_out_q;
    steps_done_d = steps_done_q;
    target_d     = target_q;
    done_d       = (state_q == S_DONE);
    overrun_d    = overrun_q;
    abort_d      = abort_q;
    step_inc     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && enable) begin
          target_d     = target_steps;
          steps_done_d = '0;
          overrun_d    = 1'b0;
          abort_d      = 1'b0;
          cnt_d        = '0;
          if (target_steps == 32'd0) begin
            state_d = S_DONE;
          end else if (dir_in != dir_out_q) begin
            dir_out_d = dir_in;
            state_d   = S_SETUP;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_SETUP: begin
        if (pulse_rise) overrun_d = 1'b1;
        if (!enable) begin
          state_d = S_IDLE;
        end else if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RUN: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (pulse_rise) begin
          step_out_d   = 1'b1;
          step_inc     = 1'b1;
          steps_done_d = steps_done_q + 32'd1;
          cnt_d        = '0;
          state_d      = S_HIGH;
        end
      end
      S_HIGH: begin
        if (pulse_rise) overrun_d = 1'b1;
        // An abort seen at any point of the high time is remembered until it ends
        if (!enable) abort_d = 1'b1;
        if (cnt_q == PW_LAST) begin
          step_out_d = 1'b0;
          cnt_d      = '0;
          if (abort_q || !enable) begin
            state_d = S_IDLE;
          end else if (steps_done_q == target_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d    = S_IDLE;
        step_out_d = 1'b0;
      end
    endcase
  end

  // clr_pos wins over a coincident step
  always_comb begin
    position_d = position_q;
    if (clr_pos) begin
      position_d = '0;
    end else if (step_inc) begin
      position_d = dir_out_q ? position_q + 32'd1 : position_q - 32'd1;
    end
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      sync_q       <= '0;
      cnt_q        <= '0;
      step_out_q   <= 1'b0;
      dir_out_q    <= 1'b1;
      position_q   <= '0;
      steps_done_q <= '0;
      target_q     <= '0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      cnt_q        <= cnt_d;
      step_out_q   <= step_out_d;
      dir_out_q    <= dir_out_d;
      position_q   <= position_d;
      steps_done_q <= steps_done_d;
      target_q     <= target_d;
      done_q       <= done_d;
      overrun_q    <= overrun_d;
      abort_q      <= abort_d;
    end
  end

  assign step_out   = step_out_q;
  assign dir_out    = dir_out_q;
  assign position   = position_q;
  assign steps_done = steps_done_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_step_driver.sv
// Directed bench for step_driver: one task per scenario, expected values worked out by hand.
`timescale 1ns/1ps
module tb_step_driver;
  logic        sysclk;
  logic        reset_n;
  logic        pulse_in;
  logic        dir_in;
  logic        start;
  logic [31:0] target_steps;
  logic        enable;
  logic        clr_pos;
  logic        step_out;
  logic        dir_out;
  logic [31:0] position;
  logic [31:0] steps_done;
  logic        busy;
  logic        done;
  logic        overrun;

  int checks = 0;
  int failures = 0;

  // Pulse source: free-running square wave or a manually driven level
  logic pg_on = 1'b0;
  logic pg_level = 1'b0;
  int   pg_half = 5;
  int   pg_cnt = 0;
  logic man_pulse = 1'b0;
  assign pulse_in = pg_on ? pg_level : man_pulse;

  // Monitor state
  int cyc = 0;
  int rises = 0, dones = 0, bad_w = 0, lat_bad = 0;
  int last_w = 0, rise_cyc = 0, fall_cyc = 0, done_cyc = 0, p_rise_cyc = 0;

  step_driver #(.PULSE_W(13), .DIR_SETUP(7)) dut (
    .sysclk(sysclk), .reset_n(reset_n), .pulse_in(pulse_in), .dir_in(dir_in),
    .start(start), .target_steps(target_steps), .enable(enable), .clr_pos(clr_pos),
    .step_out(step_out), .dir_out(dir_out), .position(position),
    .steps_done(steps_done), .busy(busy), .done(done), .overrun(overrun)
  );

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  initial forever begin
    @(posedge sysclk);
    cyc++;
  end

  initial forever begin
    @(negedge sysclk);
    if (pg_on) begin
      pg_cnt++;
      if (pg_cnt >= pg_half) begin
        pg_cnt = 0;
        pg_level = ~pg_level;
      end
    end
  end

  // Pulse rising before edge k must give a step seen after edge k+2
  initial begin
    logic prev_s, prev_p;
    prev_s = 1'b0;
    prev_p = 1'b0;
    forever begin
      @(posedge sysclk);
      #2;
      if (pulse_in && !prev_p) p_rise_cyc = cyc;
      if (step_out && !prev_s) begin
        rises++;
        rise_cyc = cyc;
        if (cyc - p_rise_cyc != 2) lat_bad++;
      end
      if (!step_out && prev_s) begin
        last_w = cyc - rise_cyc;
        fall_cyc = cyc;
        if (last_w != 13) bad_w++;
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
      end
      prev_s = step_out;
      prev_p = pulse_in;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic do_start(input logic d, input logic [31:0] t);
    @(negedge sysclk);
    dir_in = d;
    target_steps = t;
    start = 1'b1;
    @(negedge sysclk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge sysclk);
      if (done) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    int r0;
    repeat (3) @(negedge sysclk);
    checks++; if (step_out !== 1'b0) begin failures++; $display("FAIL reset_step_out got=%0b exp=0", step_out); end
    checks++; if (dir_out !== 1'b1) begin failures++; $display("FAIL reset_dir_out got=%0b exp=1", dir_out); end
    checks++; if (position !== 32'd0) begin failures++; $display("FAIL reset_position got=%h exp=0", position); end
    checks++; if (steps_done !== 32'd0) begin failures++; $display("FAIL reset_steps_done got=%h exp=0", steps_done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%0b exp=0", overrun); end
    reset_n = 1'b1;
    r0 = rises;
    pg_half = 5;
    pg_on = 1'b1;
    repeat (40) @(negedge sysclk);
    checks++; if (rises - r0 != 0) begin failures++; $display("FAIL idle_no_steps got=%0d exp=0", rises - r0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%0b exp=0", busy); end
    $display("test_reset done: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_basic();
    int r0, w0, l0, d0;
    bit ok;
    pg_half = 50;
    r0 = rises; w0 = bad_w; l0 = lat_bad; d0 = dones;
    do_start(1'b1, 32'd5);
    wait_done(2000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL basic_done_timeout got=0 exp=1"); end
    repeat (5) @(negedge sysclk);
    checks++; if (rises - r0 != 5) begin failures++; $display("FAIL basic_pulse_count got=%0d exp=5", rises - r0); end
    checks++; if (bad_w - w0 != 0 || last_w != 13) begin failures++; $display("FAIL basic_width got=%0d bad=%0d exp=13", last_w, bad_w - w0); end
    checks++; if (lat_bad - l0 != 0) begin failures++; $display("FAIL basic_latency bad=%0d exp=0", lat_bad - l0); end
    checks++; if (position !== 32'd5) begin failures++; $display("FAIL basic_position got=%h exp=5", position); end
    checks++; if (steps_done !== 32'd5) begin failures++; $display("FAIL basic_steps_done got=%h exp=5", steps_done); end
    checks++; if (dones - d0 != 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", dones - d0); end
    checks++; if (done_cyc - fall_cyc != 1) begin failures++; $display("FAIL basic_done_after_fall got=%0d exp=1", done_cyc - fall_cyc); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_end got=%0b exp=0", busy); end
    $display("test_basic done: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_dir_setup();
    int s_cyc, first;
    bit ok;
    do_start(1'b0, 32'd3);
    s_cyc = cyc;
    checks++; if (dir_out !== 1'b0) begin failures++; $display("FAIL dir_toggle got=%0b exp=0", dir_out); end
    first = -1;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge sysclk);
      if (step_out && first < 0) first = cyc;
      if (done) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin failures++; $display("FAIL dir_done_timeout got=0 exp=1"); end
    checks++; if (first < 0 || first - s_cyc < 8) begin failures++; $display("FAIL dir_setup_time got=%0d exp>=8", first - s_cyc); end
    checks++; if (position !== 32'd2) begin failures++; $display("FAIL dir_position got=%h exp=2", position); end
    checks++; if (steps_done !== 32'd3) begin failures++; $display("FAIL dir_steps_done got=%h exp=3", steps_done); end
    $display("test_dir_setup done: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_overrun();
    int r0, w0;
    bit ok;
    pg_half = 5;
    repeat (3) @(negedge sysclk);
    r0 = rises; w0 = bad_w;
    do_start(1'b0, 32'd4);
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_cleared_on_start got=%0b exp=0", overrun); end
    wait_done(2000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL ovr_done_timeout got=0 exp=1"); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got=%0b exp=1", overrun); end
    repeat (20) @(negedge sysclk);
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%0b exp=1", overrun); end
    checks++; if (bad_w - w0 != 0) begin failures++; $display("FAIL ovr_width bad=%0d exp=0 last=%0d", bad_w - w0, last_w); end
    checks++; if (steps_done !== 32'd4 || rises - r0 != 4) begin failures++; $display("FAIL ovr_steps got=%0d pulses=%0d exp=4", steps_done, rises - r0); end
    checks++; if (position !== 32'hFFFF_FFFE) begin failures++; $display("FAIL ovr_position got=%h exp=fffffffe", position); end
    $display("test_overrun done: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_abort();
    int r0, d0;
    bit ok;
    pg_half = 50;
    repeat (3) @(negedge sysclk);
    r0 = rises; d0 = dones;
    do_start(1'b0, 32'd100);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge sysclk);
      if (step_out) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin failures++; $display("FAIL abort_first_step_timeout got=0 exp=1"); end
    repeat (4) @(negedge sysclk);
    enable = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge sysclk);
      if (!step_out) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin failures++; $display("FAIL abort_fall_timeout got=0 exp=1"); end
    checks++; if (last_w != 13) begin failures++; $display("FAIL abort_width got=%0d exp=13", last_w); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_idle got=%0b exp=0", busy); end
    repeat (200) @(negedge sysclk);
    checks++; if (dones - d0 != 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", dones - d0); end
    checks++; if (rises - r0 != 1 || steps_done !== 32'd1) begin failures++; $display("FAIL abort_steps got=%0d pulses=%0d exp=1", steps_done, rises - r0); end
    checks++; if (position !== 32'hFFFF_FFFD) begin failures++; $display("FAIL abort_position got=%h exp=fffffffd", position); end
    enable = 1'b1;
    $display("test_abort done: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_zero_target();
    int r0;
    pg_on = 1'b0;
    man_pulse = 1'b0;
    repeat (3) @(negedge sysclk);
    r0 = rises;
    do_start(1'b0, 32'd0);
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL zero_cycle1 busy=%0b done=%0b exp busy=1 done=0", busy, done); end
    @(negedge sysclk);
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL zero_cycle2 done=%0b busy=%0b exp done=1 busy=0", done, busy); end
    @(negedge sysclk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL zero_done_width got=%0b exp=0", done); end
    checks++; if (steps_done !== 32'd0 || rises - r0 != 0) begin failures++; $display("FAIL zero_no_steps got=%0d pulses=%0d exp=0", steps_done, rises - r0); end
    $display("test_zero_target done: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_wrap();
    bit ok;
    @(negedge sysclk);
    force dut.position_q = 32'h7FFF_FFFF;
    @(negedge sysclk);
    release dut.position_q;
    do_start(1'b1, 32'd1);
    checks++; if (dir_out !== 1'b1) begin failures++; $display("FAIL wrap_dir got=%0b exp=1", dir_out); end
    repeat (10) @(negedge sysclk);
    man_pulse = 1'b1;
    repeat (2) @(negedge sysclk);
    checks++; if (step_out !== 1'b0) begin failures++; $display("FAIL latency_early got=%0b exp=0", step_out); end
    @(negedge sysclk);
    checks++; if (step_out !== 1'b1) begin failures++; $display("FAIL latency_on_time got=%0b exp=1", step_out); end
    checks++; if (position !== 32'h8000_0000) begin failures++; $display("FAIL wrap_position got=%h exp=80000000", position); end
    wait_done(100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL wrap_done_timeout got=0 exp=1"); end
    $display("test_wrap done: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_clr_pos();
    bit ok;
    man_pulse = 1'b0;
    repeat (4) @(negedge sysclk);
    do_start(1'b1, 32'd1);
    man_pulse = 1'b1;
    @(negedge sysclk);
    @(negedge sysclk);
    clr_pos = 1'b1;
    @(negedge sysclk);
    clr_pos = 1'b0;
    checks++; if (step_out !== 1'b1 || steps_done !== 32'd1) begin failures++; $display("FAIL clr_step_issued step=%0b steps=%0d exp 1/1", step_out, steps_done); end
    checks++; if (position !== 32'd0) begin failures++; $display("FAIL clr_priority got=%h exp=0", position); end
    wait_done(100, ok);
    checks++; if (!ok || position !== 32'd0) begin failures++; $display("FAIL clr_after_move got=%h done=%0b exp=0", position, ok); end
    $display("test_clr_pos done: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_async_reset();
    man_pulse = 1'b0;
    repeat (4) @(negedge sysclk);
    do_start(1'b1, 32'd10);
    man_pulse = 1'b1;
    repeat (3) @(negedge sysclk);
    checks++; if (step_out !== 1'b1) begin failures++; $display("FAIL areset_pre_step got=%0b exp=1", step_out); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (step_out !== 1'b0) begin failures++; $display("FAIL areset_step_out got=%0b exp=0", step_out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL areset_busy got=%0b exp=0", busy); end
    checks++; if (position !== 32'd0 || steps_done !== 32'd0) begin failures++; $display("FAIL areset_counts pos=%h steps=%h exp=0", position, steps_done); end
    @(negedge sysclk);
    reset_n = 1'b1;
    $display("test_async_reset done: checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    reset_n = 1'b0;
    dir_in = 1'b1;
    start = 1'b0;
    target_steps = 32'd0;
    enable = 1'b1;
    clr_pos = 1'b0;
    test_reset();
    test_basic();
    test_dir_setup();
    test_overrun();
    test_abort();
    test_zero_target();
    test_wrap();
    test_clr_pos();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
